// File: rtl/cmd_hdr_parser_if.sv
// Bus bundle between the command-header parser and its host Rx / executor neighbours.
// master is the parser side; slave is the host/executor side.
interface cmd_hdr_parser_if;
  logic        i_rx_valid;
  logic [7:0]  i_rx_data;
  logic        o_rx_ready;
  logic        o_mreq_valid;
  logic        i_mreq_ready;
  logic [43:0] o_mreq;
  logic        o_data_valid;
  logic [7:0]  o_data;
  logic        i_data_ready;
  logic        o_err;

  modport master (
    input  i_rx_valid, i_rx_data, i_mreq_ready, i_data_ready,
    output o_rx_ready, o_mreq_valid, o_mreq, o_data_valid, o_data, o_err
  );

  modport slave (
    output i_rx_valid, i_rx_data, i_mreq_ready, i_data_ready,
    input  o_rx_ready, o_mreq_valid, o_mreq, o_data_valid, o_data, o_err
  );
endinterface

// File: rtl/cmd_hdr_parser.sv
// Assembles a 6-byte command header into an MREQ word, then forwards the Rx
// stream to the executor as write payload until the MREQ is consumed.
module cmd_hdr_parser #(
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int MREQ_NBIT      = 44
) (
  input logic               i_clk,
  input logic               i_rst_n,
  cmd_hdr_parser_if.master  bus
);

  localparam int                IDLE_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_OPCODE,
    ST_COUNT,
    ST_ADDR,
    ST_ISSUE
  } state_t;

  state_t            state_reg, state_next;
  logic              wr_reg, wr_next;
  logic              aincr_reg, aincr_next;
  logic [1:0]        wsize_reg, wsize_next;
  logic [7:0]        wcount_reg, wcount_next;
  logic [31:0]       addr_reg, addr_next;
  logic [1:0]        ctr_reg, ctr_next;
  logic [IDLE_W-1:0] idle_reg, idle_next;
  logic              err_reg, err_next;

  logic                 rx_ready;
  logic                 rx_ack;
  logic [MREQ_NBIT-1:0] mreq_word;

  // In ISSUE the executor's ready is passed straight back to the host.
  assign rx_ready = (state_reg == ST_ISSUE) ? bus.i_data_ready : 1'b1;
  assign rx_ack   = bus.i_rx_valid & rx_ready;

  assign mreq_word = {wr_reg, aincr_reg, wsize_reg, wcount_reg, addr_reg};

  assign bus.o_rx_ready   = rx_ready & i_rst_n;
  assign bus.o_mreq_valid = (state_reg == ST_ISSUE);
  assign bus.o_mreq       = mreq_word;
  assign bus.o_data_valid = (state_reg == ST_ISSUE) & bus.i_rx_valid;
  assign bus.o_data       = (state_reg == ST_ISSUE) ? bus.i_rx_data : 8'h00;
  assign bus.o_err        = err_reg;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg  <= ST_OPCODE;
      wr_reg     <= 1'b0;
      aincr_reg  <= 1'b0;
      wsize_reg  <= 2'b00;
      wcount_reg <= 8'h00;
      addr_reg   <= 32'h0;
      ctr_reg    <= 2'b00;
      idle_reg   <= '0;
      err_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      wr_reg     <= wr_next;
      aincr_reg  <= aincr_next;
      wsize_reg  <= wsize_next;
      wcount_reg <= wcount_next;
      addr_reg   <= addr_next;
      ctr_reg    <= ctr_next;
      idle_reg   <= idle_next;
      err_reg    <= err_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    wr_next     = wr_reg;
    aincr_next  = aincr_reg;
    wsize_next  = wsize_reg;
    wcount_next = wcount_reg;
    addr_next   = addr_reg;
    ctr_next    = ctr_reg;
    idle_next   = '0;
    err_next    = 1'b0;

    case (state_reg)
      ST_OPCODE: begin
        if (rx_ack) begin
          if (bus.i_rx_data[3:0] == 4'hA) begin
            wr_next    = bus.i_rx_data[7];
            aincr_next = bus.i_rx_data[6];
            wsize_next = bus.i_rx_data[5:4];
            state_next = ST_COUNT;
          end else begin
            err_next = 1'b1;
          end
        end
      end
      ST_COUNT: begin
        if (rx_ack) begin
          wcount_next = bus.i_rx_data;
          ctr_next    = 2'b00;
          state_next  = ST_ADDR;
        end else if (idle_reg == IDLE_LAST) begin
          err_next   = 1'b1;
          state_next = ST_OPCODE;
        end else begin
          idle_next = idle_reg + 1'b1;
        end
      end
      ST_ADDR: begin
        if (rx_ack) begin
          addr_next[{ctr_reg, 3'b000} +: 8] = bus.i_rx_data;
          ctr_next = ctr_reg + 2'd1;
          if (ctr_reg == 2'd3) state_next = ST_ISSUE;
        end else if (idle_reg == IDLE_LAST) begin
          err_next   = 1'b1;
          state_next = ST_OPCODE;
        end else begin
          idle_next = idle_reg + 1'b1;
        end
      end
      ST_ISSUE: begin
        // Bytes handshaked here belong to the executor, even in the release cycle.
        if (bus.i_mreq_ready) state_next = ST_OPCODE;
      end
      default: state_next = ST_OPCODE;
    endcase
  end

endmodule

// File: tb/tb_cmd_hdr_parser.sv
// Directed bench for cmd_hdr_parser: write/read headers, resync, timeout,
// pass-through backpressure and reset mid-header.
module tb_cmd_hdr_parser;

  localparam int TO = 8;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  logic prev_err;
  int   dut_hs;
  int   idx;
  logic [63:0] pl;
  logic [15:0] rdy_pat;

  cmd_hdr_parser_if bus ();

  cmd_hdr_parser #(.TIMEOUT_CYCLES(TO)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called just after a posedge; the byte is taken on the following posedge.
  task automatic send_byte(input logic [7:0] b);
    bus.i_rx_valid = 1'b1;
    bus.i_rx_data  = b;
    @(negedge clk);
    chk("hdr_rx_ready", bus.o_rx_ready, 1);
    chk("hdr_mreq_valid", bus.o_mreq_valid, 0);
    prev_err = bus.o_err;
    @(posedge clk); #1;
  endtask

  // Ends at the negedge of the first ISSUE cycle.
  task automatic send_hdr(input logic [47:0] h, input logic [43:0] exp_mreq, input string tag);
    for (int k = 0; k < 6; k++) send_byte(h[47-8*k -: 8]);
    bus.i_rx_valid = 1'b0;
    @(negedge clk);
    chk({tag, "_mreq_valid"}, bus.o_mreq_valid, 1);
    chk({tag, "_mreq"}, bus.o_mreq, exp_mreq);
    chk({tag, "_err"}, bus.o_err, 0);
  endtask

  // Called just after a posedge while in ISSUE.
  task automatic finish_issue(input string tag);
    bus.i_mreq_ready = 1'b1;
    @(negedge clk);
    chk({tag, "_hold_valid"}, bus.o_mreq_valid, 1);
    @(posedge clk); #1;
    bus.i_mreq_ready = 1'b0;
    @(negedge clk);
    chk({tag, "_rel_valid"}, bus.o_mreq_valid, 0);
    chk({tag, "_rel_rx_ready"}, bus.o_rx_ready, 1);
    chk({tag, "_rel_data_valid"}, bus.o_data_valid, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    prev_err = 1'b0;
    dut_hs = 0;
    idx = 0;
    rst_n = 1'b0;
    bus.i_rx_valid = 1'b0;
    bus.i_rx_data = 8'h00;
    bus.i_mreq_ready = 1'b0;
    bus.i_data_ready = 1'b0;

    // Reset state
    #12;
    chk("rst_rx_ready", bus.o_rx_ready, 0);
    chk("rst_mreq_valid", bus.o_mreq_valid, 0);
    chk("rst_mreq", bus.o_mreq, 0);
    chk("rst_data_valid", bus.o_data_valid, 0);
    chk("rst_err", bus.o_err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_rx_ready", bus.o_rx_ready, 1);
    @(posedge clk); #1;

    // Write command with 8 payload bytes
    send_hdr(48'h8A_01_10_00_00_00, 44'h801_0000_0010, "wr");
    @(posedge clk); #1;
    bus.i_data_ready = 1'b1;
    pl = 64'h1122_3344_5566_7788;
    for (int k = 0; k < 8; k++) begin
      bus.i_rx_valid = 1'b1;
      bus.i_rx_data  = pl[63-8*k -: 8];
      @(negedge clk);
      chk("wr_data_valid", bus.o_data_valid, 1);
      chk("wr_data", bus.o_data, pl[63-8*k -: 8]);
      chk("wr_rx_ready", bus.o_rx_ready, 1);
      chk("wr_mreq_stable", bus.o_mreq, 44'h801_0000_0010);
      @(posedge clk); #1;
    end
    bus.i_rx_valid = 1'b0;
    finish_issue("wr");

    // Read command: executor never takes payload; next header waits for release
    bus.i_data_ready = 1'b0;
    send_hdr(48'h6A_03_00_01_00_00, 44'h603_0000_0100, "rd");
    @(posedge clk); #1;
    bus.i_rx_valid = 1'b1;
    bus.i_rx_data  = 8'h8A;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rd_rx_ready", bus.o_rx_ready, 0);
      chk("rd_mreq_valid", bus.o_mreq_valid, 1);
      @(posedge clk); #1;
    end
    bus.i_mreq_ready = 1'b1;
    @(negedge clk);
    chk("rd_rel_rx_ready", bus.o_rx_ready, 0);
    @(posedge clk); #1;
    bus.i_mreq_ready = 1'b0;
    send_hdr(48'h8A_02_78_56_34_12, 44'h802_1234_5678, "rd_next");
    @(posedge clk); #1;
    finish_issue("rd_next");

    // Resync after two bad opcodes
    send_byte(8'h55);
    send_byte(8'h00);
    chk("resync_err_55", prev_err, 1);
    send_byte(8'h8A);
    chk("resync_err_00", prev_err, 1);
    send_byte(8'h05);
    chk("resync_err_8a", prev_err, 0);
    send_byte(8'hEF);
    send_byte(8'hBE);
    send_byte(8'hAD);
    send_byte(8'hDE);
    bus.i_rx_valid = 1'b0;
    @(negedge clk);
    chk("resync_mreq_valid", bus.o_mreq_valid, 1);
    chk("resync_mreq", bus.o_mreq, 44'h805_DEAD_BEEF);
    @(posedge clk); #1;
    finish_issue("resync");

    // Timeout after opcode+count, then a clean header
    send_byte(8'h8A);
    send_byte(8'h01);
    bus.i_rx_valid = 1'b0;
    for (int k = 0; k < TO; k++) begin
      @(negedge clk);
      chk("to_no_early_err", bus.o_err, 0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("to_err", bus.o_err, 1);
    chk("to_rx_ready", bus.o_rx_ready, 1);
    chk("to_mreq_valid", bus.o_mreq_valid, 0);
    @(posedge clk); #1;
    send_hdr(48'h8A_00_AA_00_00_00, 44'h800_0000_00AA, "to_after");
    @(posedge clk); #1;
    finish_issue("to_after");

    // Pass-through backpressure with rx_valid held high
    send_hdr(48'h9A_07_04_03_02_01, 44'h907_0102_0304, "bp");
    @(posedge clk); #1;
    rdy_pat = 16'b1011_0010_0110_1101;
    idx = 0;
    dut_hs = 0;
    for (int c = 0; c < 16; c++) begin
      bus.i_data_ready = rdy_pat[15-c];
      bus.i_rx_valid   = 1'b1;
      bus.i_rx_data    = 8'hA0 + 8'(idx);
      @(negedge clk);
      chk("bp_data_valid", bus.o_data_valid, 1);
      chk("bp_data", bus.o_data, 8'hA0 + 8'(idx));
      chk("bp_rx_ready", bus.o_rx_ready, rdy_pat[15-c]);
      chk("bp_mreq_stable", bus.o_mreq, 44'h907_0102_0304);
      if (bus.o_data_valid && bus.o_rx_ready) dut_hs++;
      @(posedge clk); #1;
      if (rdy_pat[15-c]) idx++;
    end
    chk("bp_handshakes", dut_hs, 9);
    bus.i_rx_valid = 1'b0;
    bus.i_data_ready = 1'b0;
    finish_issue("bp");

    // Asynchronous reset after four header bytes
    send_byte(8'h8A);
    send_byte(8'h01);
    send_byte(8'h10);
    send_byte(8'h20);
    bus.i_rx_valid = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_rx_ready", bus.o_rx_ready, 0);
    chk("arst_mreq_valid", bus.o_mreq_valid, 0);
    chk("arst_mreq", bus.o_mreq, 0);
    chk("arst_data_valid", bus.o_data_valid, 0);
    chk("arst_err", bus.o_err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    send_hdr(48'h4A_FF_44_33_22_11, 44'h4FF_1122_3344, "arst_after");
    @(posedge clk); #1;
    finish_issue("arst_after");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
